// File: rtl/exec_muldiv_if.sv
// Issue, result and forwarding bundle for the integer ALU / multiply-divide execute stage.
interface exec_muldiv_if #(
    parameter int XLEN  = 64,
    parameter int REG_W = 5
);
    // An op transfers on a rising edge where in_valid && in_ready. While in_valid is high
    // and in_ready is low the producer keeps every in_* field stable. out_valid is a
    // one-cycle pulse per completed op; results cannot be back-pressured except via hold.
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic             in_word;
    logic             in_src_imm;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_pc;
    logic             in_wb;
    logic [REG_W-1:0] in_wd;
    logic             hold;
    logic             flush;
    logic             out_valid;
    logic [XLEN-1:0]  out_result;
    logic [XLEN-1:0]  out_rs2;
    logic [XLEN-1:0]  out_pc;
    logic             out_wb;
    logic [REG_W-1:0] out_wd;
    logic             fwd_valid;
    logic             fwd_busy;
    logic [REG_W-1:0] fwd_wd;
    logic [XLEN-1:0]  fwd_data;

    modport master (
        output in_valid, in_op, in_word, in_src_imm, in_rs1, in_rs2, in_imm, in_pc,
               in_wb, in_wd, hold, flush,
        input  in_ready, out_valid, out_result, out_rs2, out_pc, out_wb, out_wd,
               fwd_valid, fwd_busy, fwd_wd, fwd_data
    );

    modport slave (
        input  in_valid, in_op, in_word, in_src_imm, in_rs1, in_rs2, in_imm, in_pc,
               in_wb, in_wd, hold, flush,
        output in_ready, out_valid, out_result, out_rs2, out_pc, out_wb, out_wd,
               fwd_valid, fwd_busy, fwd_wd, fwd_data
    );
endinterface

// File: rtl/exec_muldiv_stage.sv
// Execute stage: single-cycle ALU ops plus iterative shift-add multiply and restoring divide.
module exec_muldiv_stage #(
    parameter int XLEN  = 64,
    parameter int REG_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    exec_muldiv_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] { IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2 } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [3:0]       p_op;
    logic             p_word;
    logic             p_wb;
    logic             neg_q;
    logic             neg_r;
    logic [REG_W-1:0] p_wd;
    logic [XLEN-1:0]  p_rs2;
    logic [XLEN-1:0]  p_pc;
    logic [XLEN-1:0]  p_res;
    logic [XLEN-1:0]  opa;
    logic [XLEN-1:0]  opb;
    logic [XLEN-1:0]  acc;

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        r = '0;
        r[31:0] = v;
        for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
        return r;
    endfunction

    logic [XLEN-1:0] b_sel, a_x, b_x, alu_raw, alu_res, a_mag, b_mag, min_val, byp_raw, byp_res;
    logic [SW-1:0]   shamt;
    logic [CW-1:0]   width;
    logic            is_md, is_uns, div_sgn, is_rem, a_neg, b_neg, div_zero, div_ovf, accept;

    always_comb begin
        b_sel   = bus.in_src_imm ? bus.in_imm : bus.in_rs2;
        is_md   = (bus.in_op >= 4'd10) && (bus.in_op <= 4'd14);
        is_uns  = bus.in_op inside {4'd6, 4'd9, 4'd12, 4'd14};
        a_x     = bus.in_word ? ext32(bus.in_rs1[31:0], ~is_uns) : bus.in_rs1;
        b_x     = bus.in_word ? ext32(b_sel[31:0], ~is_uns) : b_sel;
        shamt   = bus.in_word ? SW'(b_sel[4:0]) : b_sel[SW-1:0];
        width   = bus.in_word ? CW'(32) : CW'(XLEN);
        case (bus.in_op)
            4'd1:    alu_raw = a_x - b_x;
            4'd2:    alu_raw = a_x & b_x;
            4'd3:    alu_raw = a_x | b_x;
            4'd4:    alu_raw = a_x ^ b_x;
            4'd5:    alu_raw = a_x << shamt;
            4'd6:    alu_raw = a_x >> shamt;
            4'd7:    alu_raw = $signed(a_x) >>> shamt;
            4'd8:    alu_raw = XLEN'($signed(a_x) < $signed(b_x));
            4'd9:    alu_raw = XLEN'(a_x < b_x);
            default: alu_raw = a_x + b_x;
        endcase
        alu_res = bus.in_word ? ext32(alu_raw[31:0], 1'b1) : alu_raw;

        // Divides iterate on magnitudes; the signs are reapplied when the result is formed.
        div_sgn = (bus.in_op == 4'd11) || (bus.in_op == 4'd13);
        is_rem  = (bus.in_op == 4'd13) || (bus.in_op == 4'd14);
        a_neg   = div_sgn & a_x[XLEN-1];
        b_neg   = div_sgn & b_x[XLEN-1];
        a_mag   = a_neg ? -a_x : a_x;
        b_mag   = b_neg ? -b_x : b_x;
        min_val = '0;
        if (bus.in_word) begin
            min_val       = '1;
            min_val[30:0] = '0;
        end else begin
            min_val[XLEN-1] = 1'b1;
        end
        div_zero = (b_x == '0);
        div_ovf  = div_sgn && (a_x == min_val) && (b_x == '1);
        if (div_zero) byp_raw = is_rem ? a_x : '1;
        else          byp_raw = is_rem ? '0 : a_x;
        byp_res = bus.in_word ? ext32(byp_raw[31:0], 1'b1) : byp_raw;
    end

    logic [XLEN-1:0] mul_acc, div_quo, div_rem, acc_n, opa_n, opb_n, fin_raw, fin_res;
    logic [XLEN:0]   sh_rem, div_dif;
    logic            ge, p_mul;

    always_comb begin
        p_mul   = (p_op == 4'd10);
        mul_acc = acc + (opb[0] ? opa : '0);
        sh_rem  = {acc, opa[XLEN-1]};
        div_dif = sh_rem - {1'b0, opb};
        ge      = ~div_dif[XLEN];
        div_rem = ge ? div_dif[XLEN-1:0] : sh_rem[XLEN-1:0];
        div_quo = {opa[XLEN-2:0], ge};
        acc_n   = p_mul ? mul_acc : div_rem;
        opa_n   = p_mul ? (opa << 1) : div_quo;
        opb_n   = p_mul ? (opb >> 1) : opb;
        case (p_op)
            4'd11, 4'd12: fin_raw = neg_q ? -div_quo : div_quo;
            4'd13, 4'd14: fin_raw = neg_r ? -div_rem : div_rem;
            default:      fin_raw = mul_acc;
        endcase
        fin_res = p_word ? ext32(fin_raw[31:0], 1'b1) : fin_raw;
    end

    assign bus.in_ready = (state == IDLE) & ~bus.hold & ~bus.flush;
    assign accept       = bus.in_valid & bus.in_ready;
    assign dbg_state    = state;

    always_comb begin
        bus.fwd_busy  = (state == BUSY);
        bus.fwd_valid = 1'b0;
        bus.fwd_wd    = p_wd;
        bus.fwd_data  = p_res;
        if (state == IDLE) begin
            bus.fwd_valid = bus.in_valid & bus.in_wb & (bus.in_op <= 4'd9);
            bus.fwd_wd    = bus.in_wd;
            bus.fwd_data  = alu_res;
        end else if (state == DONE) begin
            bus.fwd_valid = p_wb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            p_op           <= '0;
            p_word         <= 1'b0;
            p_wb           <= 1'b0;
            p_wd           <= '0;
            p_rs2          <= '0;
            p_pc           <= '0;
            p_res          <= '0;
            opa            <= '0;
            opb            <= '0;
            acc            <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_rs2    <= '0;
            bus.out_pc     <= '0;
            bus.out_wb     <= 1'b0;
            bus.out_wd     <= '0;
        end else if (bus.flush) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.out_valid <= 1'b0;
                    if (accept) begin
                        p_op   <= bus.in_op;
                        p_word <= bus.in_word;
                        p_wb   <= bus.in_wb;
                        p_wd   <= bus.in_wd;
                        p_rs2  <= bus.in_rs2;
                        p_pc   <= bus.in_pc;
                        if (!is_md) begin
                            bus.out_valid  <= 1'b1;
                            bus.out_result <= alu_res;
                            bus.out_rs2    <= bus.in_rs2;
                            bus.out_pc     <= bus.in_pc;
                            bus.out_wb     <= bus.in_wb;
                            bus.out_wd     <= bus.in_wd;
                        end else if (bus.in_op == 4'd10) begin
                            state <= BUSY;
                            cnt   <= width;
                            opa   <= bus.in_rs1;
                            opb   <= b_sel;
                            acc   <= '0;
                        end else if (div_zero || div_ovf) begin
                            state <= DONE;
                            p_res <= byp_res;
                        end else begin
                            // Word divides keep the dividend left-aligned so 32 steps see all of it.
                            state <= BUSY;
                            cnt   <= width;
                            opa   <= bus.in_word ? (a_mag << (XLEN - 32)) : a_mag;
                            opb   <= b_mag;
                            acc   <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                        end
                    end
                end
                BUSY: begin
                    bus.out_valid <= 1'b0;
                    acc           <= acc_n;
                    opa           <= opa_n;
                    opb           <= opb_n;
                    cnt           <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        p_res <= fin_res;
                    end
                end
                DONE: begin
                    if (bus.hold) begin
                        bus.out_valid <= 1'b0;
                    end else begin
                        state          <= IDLE;
                        bus.out_valid  <= 1'b1;
                        bus.out_result <= p_res;
                        bus.out_rs2    <= p_rs2;
                        bus.out_pc     <= p_pc;
                        bus.out_wb     <= p_wb;
                        bus.out_wd     <= p_wd;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exec_muldiv_stage.sv
// Scoreboard bench for exec_muldiv_stage: directed latency/hold/flush/reset cases plus random ops.
module tb_exec_muldiv_stage;
    localparam int XLEN  = 64;
    localparam int REG_W = 5;
    localparam int EW    = 2 * XLEN + REG_W + XLEN;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    exec_muldiv_if #(.XLEN(XLEN), .REG_W(REG_W)) bus ();

    exec_muldiv_stage #(.XLEN(XLEN), .REG_W(REG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [31:0] x, y, r;
        logic [63:0] q;
        x = a[31:0];
        y = b[31:0];
        r = '0;
        q = '0;
        if (w) begin
            case (op)
                4'd1:  r = x - y;
                4'd2:  r = x & y;
                4'd3:  r = x | y;
                4'd4:  r = x ^ y;
                4'd5:  r = x << y[4:0];
                4'd6:  r = x >> y[4:0];
                4'd7:  r = $signed(x) >>> y[4:0];
                4'd8:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                4'd9:  r = (x < y) ? 32'd1 : 32'd0;
                4'd10: r = x * y;
                4'd11: begin
                    if (y == 0) r = '1;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                    else r = $signed(x) / $signed(y);
                end
                4'd12: begin
                    if (y == 0) r = '1;
                    else r = x / y;
                end
                4'd13: begin
                    if (y == 0) r = x;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = '0;
                    else r = $signed(x) % $signed(y);
                end
                4'd14: begin
                    if (y == 0) r = x;
                    else r = x % y;
                end
                default: r = x + y;
            endcase
            return {{32{r[31]}}, r};
        end
        case (op)
            4'd1:  q = a - b;
            4'd2:  q = a & b;
            4'd3:  q = a | b;
            4'd4:  q = a ^ b;
            4'd5:  q = a << b[5:0];
            4'd6:  q = a >> b[5:0];
            4'd7:  q = $signed(a) >>> b[5:0];
            4'd8:  q = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9:  q = (a < b) ? 64'd1 : 64'd0;
            4'd10: q = a * b;
            4'd11: begin
                if (b == 0) q = '1;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) q = a;
                else q = $signed(a) / $signed(b);
            end
            4'd12: begin
                if (b == 0) q = '1;
                else q = a / b;
            end
            4'd13: begin
                if (b == 0) q = a;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) q = '0;
                else q = $signed(a) % $signed(b);
            end
            4'd14: begin
                if (b == 0) q = a;
                else q = a % b;
            end
            default: q = a + b;
        endcase
        return q;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return 64'($urandom_range(0, 40));
            5:       return 64'h0000_0000_7FFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // driver: offers one op, waits (bounded) for acceptance, optionally scoreboards it
    task automatic issue(input logic [3:0] op, input bit w, input bit imm_sel,
                         input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input bit push);
        logic [63:0] exp, pc;
        logic [REG_W-1:0] wd;
        bit ok;
        exp = model(op, w, rs1, imm_sel ? imm : rs2);
        pc  = {$urandom, $urandom} & ~64'h3;
        wd  = REG_W'($urandom_range(1, 31));
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_word    = w;
        bus.in_src_imm = imm_sel;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_imm     = imm;
        bus.in_pc      = pc;
        bus.in_wb      = 1'b1;
        bus.in_wd      = wd;
        #1;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("accept", 64'(ok), 64'd1);
        if (ok) begin
            check("fwd_valid_idle", 64'(bus.fwd_valid), (op <= 4'd9) ? 64'd1 : 64'd0);
            if (op <= 4'd9) begin
                check("fwd_data_idle", bus.fwd_data, exp);
                check("fwd_wd_idle", 64'(bus.fwd_wd), 64'(wd));
            end
            if (push) exp_q.push_back({exp, pc, wd, rs2});
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every out_valid pulse must match the oldest expected op
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", bus.out_result, mon_e[EW-1 -: 64]);
                check("pc", bus.out_pc, mon_e[EW-65 -: 64]);
                check("wd", 64'(bus.out_wd), 64'(mon_e[XLEN +: REG_W]));
                check("rs2", bus.out_rs2, mon_e[XLEN-1:0]);
                check("wb", 64'(bus.out_wb), 64'd1);
            end
        end
    end

    initial begin
        int busy_cnt;
        bit seen;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_op      = '0;
        bus.in_word    = 1'b0;
        bus.in_src_imm = 1'b0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_imm     = '0;
        bus.in_pc      = '0;
        bus.in_wb      = 1'b0;
        bus.in_wd      = '0;
        bus.hold       = 1'b0;
        bus.flush      = 1'b0;
        #12;
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_fwd_busy", 64'(bus.fwd_busy), 64'd0);
        check("rst_out_result", bus.out_result, 64'd0);
        check("rst_out_pc", bus.out_pc, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // ADD with immediate, latency 1
        issue(4'd0, 1'b0, 1'b1, 64'd5, 64'd99, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
        check("add_lat1", 64'(bus.out_valid), 64'd1);
        check("add_state", 64'(dbg_state), 64'd0);
        drain();

        // ADDW overflow into bit 31 sign-extends
        issue(4'd0, 1'b1, 1'b0, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b1);
        check("addw_lat1", 64'(bus.out_valid), 64'd1);
        drain();

        // MUL: 64 busy cycles, one DONE cycle, then the result
        issue(4'd10, 1'b0, 1'b0, -64'sd3, 64'd7, 64'd0, 1'b1);
        busy_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.fwd_busy && !bus.in_ready && !bus.fwd_valid) busy_cnt++;
            else break;
            @(posedge clk);
            #1;
        end
        check("mul_busy_cycles", 64'(busy_cnt), 64'd64);
        check("mul_done_state", 64'(dbg_state), 64'd2);
        check("mul_done_no_out", 64'(bus.out_valid), 64'd0);
        check("mul_fwd_valid", 64'(bus.fwd_valid), 64'd1);
        check("mul_fwd_data", bus.fwd_data, 64'hFFFF_FFFF_FFFF_FFEB);
        @(posedge clk);
        #1;
        check("mul_out_valid_65", 64'(bus.out_valid), 64'd1);
        drain();

        // divide-by-zero and overflow bypass straight to DONE
        issue(4'd11, 1'b0, 1'b0, 64'd20, 64'd0, 64'd0, 1'b1);
        check("div0_done", 64'(dbg_state), 64'd2);
        check("div0_no_out_yet", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("div0_out_2cyc", 64'(bus.out_valid), 64'd1);
        drain();
        issue(4'd13, 1'b0, 1'b0, 64'd20, 64'd0, 64'd0, 1'b1);
        drain();
        issue(4'd11, 1'b0, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1'b1);
        check("divovf_done", 64'(dbg_state), 64'd2);
        drain();
        issue(4'd13, 1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b1);
        drain();

        // DIVU held at completion for 3 cycles
        issue(4'd12, 1'b0, 1'b0, 64'd100, 64'd7, 64'd0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (dbg_state == 2'd2) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("divu_reach_done", 64'(seen), 64'd1);
        bus.hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("hold_state", 64'(dbg_state), 64'd2);
            check("hold_no_out", 64'(bus.out_valid), 64'd0);
            check("hold_fwd_valid", 64'(bus.fwd_valid), 64'd1);
            check("hold_fwd_data", bus.fwd_data, 64'd14);
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        bus.hold = 1'b0;
        @(posedge clk);
        #1;
        check("hold_release_out", 64'(bus.out_valid), 64'd1);
        drain();

        // flush on busy cycle 10 of a MUL
        issue(4'd10, 1'b0, 1'b0, 64'd123, 64'd456, 64'd0, 1'b0);
        idle_cycles(9);
        check("flush_pre_busy", 64'(bus.fwd_busy), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_idle", 64'(dbg_state), 64'd0);
        check("flush_no_out", 64'(bus.out_valid), 64'd0);
        check("flush_not_busy", 64'(bus.fwd_busy), 64'd0);
        idle_cycles(70);
        issue(4'd0, 1'b0, 1'b0, 64'd40, 64'd2, 64'd0, 1'b1);
        check("post_flush_add", 64'(bus.out_valid), 64'd1);
        drain();

        // asynchronous reset in the middle of a divide
        issue(4'd14, 1'b0, 1'b0, 64'd1000, 64'd33, 64'd0, 1'b0);
        idle_cycles(5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 64'(dbg_state), 64'd0);
        check("async_rst_busy", 64'(bus.fwd_busy), 64'd0);
        check("async_rst_out", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(80);

        // random mix of every opcode, word and full width
        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  pick(), pick(), pick(), 1'b1);
            drain();
        end

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
